stack_cache_line_mp: RTL and testbench

- Next-generation stack cache line: LINESIZE data entries with per-entry dirty, pending-write and speculation state.
- Adds READPORTS independent read ports and per-entry shadow storage for speculative-write rollback.
- Adds a writeback FSM that drains dirty entries over a valid/ready port.
- Sits between the stack-cache tag/control logic and the backing-memory write path; one instance per cache line.

---
 rtl/stack_cache_line_mp.sv | 268 ++++++++++++++++++++++++++
 tb/tb_stack_cache_line_mp.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_cache_line_mp.sv
// stack_cache_line_mp: one stack-cache line with multi-port reads, per-entry
// pending-write and speculation tracking, shadow rollback and a writeback FSM.
// Optional build macro: STACKCACHE_LINE_PARITY_EN (per-entry even parity).
module stack_cache_line_mp #(
    parameter int unsigned LINESIZE     = 8,
    parameter int unsigned DATABITWIDTH = 16,
    parameter int unsigned READPORTS    = 2,
    parameter int unsigned PENDBITWIDTH = 4,
    localparam int unsigned ADDRW       = $clog2(LINESIZE)
) (
    input  logic                              clk,
    input  logic                              async_rst,
    input  logic                              clk_en,
    input  logic                              WriteEn,
    input  logic [ADDRW-1:0]                  WriteAddr,
    input  logic [DATABITWIDTH-1:0]           DataIn,
    input  logic                              ReserveEn,
    input  logic [ADDRW-1:0]                  ReserveAddr,
    input  logic                              SpecActive,
    input  logic                              SpecCommit,
    input  logic                              SpecSquash,
    input  logic [READPORTS*ADDRW-1:0]        ReadAddr,
    output logic [READPORTS*DATABITWIDTH-1:0] DataOut,
    output logic [READPORTS-1:0]              IsDirty,
    output logic [READPORTS-1:0]              HasPendingWrite,
    output logic [READPORTS-1:0]              ParityErr,
    output logic                              LineAllClean,
    input  logic                              FlushReq,
    output logic                              FlushBusy,
    output logic                              FlushDone,
    output logic                              WbValid,
    input  logic                              WbReady,
    output logic [ADDRW-1:0]                  WbIndex,
    output logic [DATABITWIDTH-1:0]           WbData
);
    localparam int unsigned DW = DATABITWIDTH;
    localparam int unsigned PW = PENDBITWIDTH;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ISSUE} state_t;

    logic [DW-1:0]       r_data   [LINESIZE];
    logic [DW-1:0]       r_shadow [LINESIZE];
    logic [PW-1:0]       r_pend   [LINESIZE];
    logic [PW-1:0]       r_spend  [LINESIZE];
    logic [LINESIZE-1:0] r_dirty, r_sdirty, r_spec;

    logic [DW-1:0]       w_data_n   [LINESIZE];
    logic [DW-1:0]       w_shadow_n [LINESIZE];
    logic [PW-1:0]       w_pend_n   [LINESIZE];
    logic [PW-1:0]       w_spend_n  [LINESIZE];
    logic [LINESIZE-1:0] w_dirty_n, w_sdirty_n, w_spec_n;
    logic [LINESIZE-1:0] w_wr_hit, w_rs_hit;

`ifdef STACKCACHE_LINE_PARITY_EN
    logic [LINESIZE-1:0] r_par, r_spar, w_par_n, w_spar_n;
`endif

    state_t            r_state, w_state_n;
    logic              r_wb_valid, w_wb_valid_n;
    logic [ADDRW-1:0]  r_wb_index, w_wb_index_n;
    logic [DW-1:0]     r_wb_data, w_wb_data_n;
    logic              r_flush_done, w_flush_done_n;
    logic              r_stale, w_stale_n;
    logic              w_wb_clear;
    logic              w_scan_hit;
    logic [ADDRW-1:0]  w_scan_idx;

    function automatic logic [PW-1:0] sat_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[PW] ? '1 : s[PW-1:0];
    endfunction

    // Per-entry write/reserve address decode
    always_comb begin
        w_wr_hit = '0;
        w_rs_hit = '0;
        for (int i = 0; i < LINESIZE; i++) begin
            w_wr_hit[i] = WriteEn   && (WriteAddr   == ADDRW'(i));
            w_rs_hit[i] = ReserveEn && (ReserveAddr == ADDRW'(i));
        end
    end

    // Handshake clears dirty unless the entry was rewritten since it was latched
    assign w_wb_clear = (r_state == S_ISSUE) && WbReady && !r_stale
                        && !(WriteEn && (WriteAddr == r_wb_index));

    // Entry next state: commit/squash first, then writeback clear, then write/reserve
    always_comb begin
        w_data_n   = r_data;
        w_shadow_n = r_shadow;
        w_pend_n   = r_pend;
        w_spend_n  = r_spend;
        w_dirty_n  = r_dirty;
        w_sdirty_n = r_sdirty;
        w_spec_n   = r_spec;
`ifdef STACKCACHE_LINE_PARITY_EN
        w_par_n    = r_par;
        w_spar_n   = r_spar;
`endif
        for (int i = 0; i < LINESIZE; i++) begin
            if (SpecSquash) begin
                if (r_spec[i]) begin
                    w_data_n[i]  = r_shadow[i];
                    w_dirty_n[i] = r_sdirty[i];
`ifdef STACKCACHE_LINE_PARITY_EN
                    w_par_n[i]   = r_spar[i];
`endif
                end
                w_spec_n[i]  = 1'b0;
                w_spend_n[i] = '0;
            end else if (SpecCommit) begin
                w_spec_n[i]  = 1'b0;
                w_pend_n[i]  = sat_add(r_pend[i], r_spend[i]);
                w_spend_n[i] = '0;
            end
            if (w_wb_clear && (r_wb_index == ADDRW'(i))) begin
                w_dirty_n[i] = 1'b0;
            end
            if (w_rs_hit[i] && !w_wr_hit[i]) begin
                if (SpecActive) w_spend_n[i] = sat_add(w_spend_n[i], PW'(1));
                else            w_pend_n[i]  = sat_add(w_pend_n[i], PW'(1));
            end
            if (w_wr_hit[i]) begin
                if (SpecActive && !w_spec_n[i]) begin
                    w_shadow_n[i] = w_data_n[i];
                    w_sdirty_n[i] = w_dirty_n[i];
                    w_spec_n[i]   = 1'b1;
`ifdef STACKCACHE_LINE_PARITY_EN
                    w_spar_n[i]   = w_par_n[i];
`endif
                end
                w_data_n[i]  = DataIn;
                w_dirty_n[i] = 1'b1;
`ifdef STACKCACHE_LINE_PARITY_EN
                w_par_n[i]   = ^DataIn;
`endif
                if (!w_rs_hit[i]) begin
                    if (w_pend_n[i] != '0)       w_pend_n[i]  = w_pend_n[i] - PW'(1);
                    else if (w_spend_n[i] != '0) w_spend_n[i] = w_spend_n[i] - PW'(1);
                end
            end
        end
    end

    // Entry storage
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            for (int i = 0; i < LINESIZE; i++) begin
                r_data[i]   <= '0;
                r_shadow[i] <= '0;
                r_pend[i]   <= '0;
                r_spend[i]  <= '0;
            end
            r_dirty  <= '0;
            r_sdirty <= '0;
            r_spec   <= '0;
`ifdef STACKCACHE_LINE_PARITY_EN
            r_par    <= '0;
            r_spar   <= '0;
`endif
        end else if (clk_en) begin
            r_data   <= w_data_n;
            r_shadow <= w_shadow_n;
            r_pend   <= w_pend_n;
            r_spend  <= w_spend_n;
            r_dirty  <= w_dirty_n;
            r_sdirty <= w_sdirty_n;
            r_spec   <= w_spec_n;
`ifdef STACKCACHE_LINE_PARITY_EN
            r_par    <= w_par_n;
            r_spar   <= w_spar_n;
`endif
        end
    end

    // Lowest-index entry that is dirty, committed and has no outstanding writes
    always_comb begin
        w_scan_hit = 1'b0;
        w_scan_idx = '0;
        for (int i = LINESIZE - 1; i >= 0; i--) begin
            if (r_dirty[i] && !r_spec[i] && (r_pend[i] == '0) && (r_spend[i] == '0)) begin
                w_scan_hit = 1'b1;
                w_scan_idx = ADDRW'(i);
            end
        end
    end

    // Writeback FSM next state and registered outputs
    always_comb begin
        w_state_n      = r_state;
        w_wb_valid_n   = r_wb_valid;
        w_wb_index_n   = r_wb_index;
        w_wb_data_n    = r_wb_data;
        w_flush_done_n = 1'b0;
        w_stale_n      = r_stale;
        case (r_state)
            S_IDLE: begin
                if (FlushReq) w_state_n = S_SCAN;
            end
            S_SCAN: begin
                if (w_scan_hit) begin
                    w_wb_index_n = w_scan_idx;
                    w_wb_data_n  = r_data[w_scan_idx];
                    w_wb_valid_n = 1'b1;
                    w_stale_n    = WriteEn && (WriteAddr == w_scan_idx);
                    w_state_n    = S_ISSUE;
                end else begin
                    w_flush_done_n = 1'b1;
                    w_state_n      = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (WriteEn && (WriteAddr == r_wb_index)) w_stale_n = 1'b1;
                if (WbReady) begin
                    w_wb_valid_n = 1'b0;
                    w_state_n    = S_SCAN;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Writeback FSM registers
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_state      <= S_IDLE;
            r_wb_valid   <= 1'b0;
            r_wb_index   <= '0;
            r_wb_data    <= '0;
            r_flush_done <= 1'b0;
            r_stale      <= 1'b0;
        end else if (clk_en) begin
            r_state      <= w_state_n;
            r_wb_valid   <= w_wb_valid_n;
            r_wb_index   <= w_wb_index_n;
            r_wb_data    <= w_wb_data_n;
            r_flush_done <= w_flush_done_n;
            r_stale      <= w_stale_n;
        end
    end

    // Independent zero-latency read ports
    always_comb begin
        logic [ADDRW-1:0] w_ra;
        DataOut         = '0;
        IsDirty         = '0;
        HasPendingWrite = '0;
        ParityErr       = '0;
        for (int p = 0; p < READPORTS; p++) begin
            w_ra = ReadAddr[p*ADDRW +: ADDRW];
            DataOut[p*DW +: DW] = r_data[w_ra];
            IsDirty[p]          = r_dirty[w_ra];
            HasPendingWrite[p]  = (r_pend[w_ra] != '0) || (r_spend[w_ra] != '0);
`ifdef STACKCACHE_LINE_PARITY_EN
            ParityErr[p]        = r_par[w_ra] ^ (^r_data[w_ra]);
`endif
        end
    end

    assign LineAllClean = ~|r_dirty;
    assign FlushBusy    = (r_state != S_IDLE);
    assign FlushDone    = r_flush_done;
    assign WbValid      = r_wb_valid;
    assign WbIndex      = r_wb_index;
    assign WbData       = r_wb_data;

endmodule

// File: tb/tb_stack_cache_line_mp.sv
// Testbench for stack_cache_line_mp: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the line.
module tb_stack_cache_line_mp;
    localparam int LS   = 8;
    localparam int DW   = 16;
    localparam int RP   = 2;
    localparam int PW   = 4;
    localparam int AW   = 3;
    localparam int PMAX = (1 << PW) - 1;

    logic            clk = 1'b0;
    logic            async_rst = 1'b0;
    logic            clk_en = 1'b1;
    logic            WriteEn = 1'b0;
    logic [AW-1:0]   WriteAddr = '0;
    logic [DW-1:0]   DataIn = '0;
    logic            ReserveEn = 1'b0;
    logic [AW-1:0]   ReserveAddr = '0;
    logic            SpecActive = 1'b0;
    logic            SpecCommit = 1'b0;
    logic            SpecSquash = 1'b0;
    logic [RP*AW-1:0] ReadAddr = '0;
    logic [RP*DW-1:0] DataOut;
    logic [RP-1:0]   IsDirty, HasPendingWrite, ParityErr;
    logic            LineAllClean, FlushReq = 1'b0, FlushBusy, FlushDone;
    logic            WbValid, WbReady = 1'b0;
    logic [AW-1:0]   WbIndex;
    logic [DW-1:0]   WbData;

    stack_cache_line_mp #(.LINESIZE(LS), .DATABITWIDTH(DW), .READPORTS(RP), .PENDBITWIDTH(PW)) dut (
        .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
        .WriteEn(WriteEn), .WriteAddr(WriteAddr), .DataIn(DataIn),
        .ReserveEn(ReserveEn), .ReserveAddr(ReserveAddr),
        .SpecActive(SpecActive), .SpecCommit(SpecCommit), .SpecSquash(SpecSquash),
        .ReadAddr(ReadAddr), .DataOut(DataOut), .IsDirty(IsDirty),
        .HasPendingWrite(HasPendingWrite), .ParityErr(ParityErr),
        .LineAllClean(LineAllClean), .FlushReq(FlushReq), .FlushBusy(FlushBusy),
        .FlushDone(FlushDone), .WbValid(WbValid), .WbReady(WbReady),
        .WbIndex(WbIndex), .WbData(WbData)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cmp_ra;

    // Behavioural model of the line
    bit [DW-1:0] m_data [LS];
    bit [DW-1:0] m_shadow [LS];
    bit          m_dirty [LS];
    bit          m_sdirty [LS];
    bit          m_spec [LS];
    int          m_pend [LS];
    int          m_spend [LS];
    int          m_phase;      // 0 idle, 1 scanning, 2 beat offered
    bit          m_wb_valid;
    int          m_wb_index;
    bit [DW-1:0] m_wb_data;
    bit          m_done;
    bit          m_stale;

    function automatic void cmp(string name, int p, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s port%0d: got %0h expected %0h at %0t", name, p, act, exp, $time);
        end
    endfunction

    function automatic int sat(int v);
        return (v > PMAX) ? PMAX : v;
    endfunction

    function automatic bit model_clean();
        for (int i = 0; i < LS; i++) if (m_dirty[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LS; i++) begin
            m_data[i] = '0; m_shadow[i] = '0; m_dirty[i] = 0; m_sdirty[i] = 0;
            m_spec[i] = 0; m_pend[i] = 0; m_spend[i] = 0;
        end
        m_phase = 0; m_wb_valid = 0; m_wb_index = 0; m_wb_data = '0; m_done = 0; m_stale = 0;
    endtask

    task automatic model_step();
        int  found = -1;
        int  wi = int'(WriteAddr);
        int  ri = int'(ReserveAddr);
        bit  hs = (m_phase == 2) && WbReady;
        bit  wr_on_wb = WriteEn && (wi == m_wb_index);
        int  clear_idx = (hs && !m_stale && !wr_on_wb) ? m_wb_index : -1;
        bit  same = WriteEn && ReserveEn && (wi == ri);
        for (int i = LS - 1; i >= 0; i--)
            if (m_dirty[i] && !m_spec[i] && m_pend[i] == 0 && m_spend[i] == 0) found = i;
        m_done = 0;
        case (m_phase)
            0: if (FlushReq) m_phase = 1;
            1: if (found >= 0) begin
                   m_wb_index = found; m_wb_data = m_data[found]; m_wb_valid = 1;
                   m_stale = WriteEn && (wi == found); m_phase = 2;
               end else begin
                   m_done = 1; m_phase = 0;
               end
            default: begin
                if (wr_on_wb) m_stale = 1;
                if (WbReady) begin m_wb_valid = 0; m_phase = 1; end
            end
        endcase
        if (SpecSquash) begin
            for (int i = 0; i < LS; i++) begin
                if (m_spec[i]) begin m_data[i] = m_shadow[i]; m_dirty[i] = m_sdirty[i]; end
                m_spec[i] = 0; m_spend[i] = 0;
            end
        end else if (SpecCommit) begin
            for (int i = 0; i < LS; i++) begin
                m_spec[i] = 0; m_pend[i] = sat(m_pend[i] + m_spend[i]); m_spend[i] = 0;
            end
        end
        if (clear_idx >= 0) m_dirty[clear_idx] = 0;
        if (ReserveEn && !same) begin
            if (SpecActive) m_spend[ri] = sat(m_spend[ri] + 1);
            else            m_pend[ri]  = sat(m_pend[ri] + 1);
        end
        if (WriteEn) begin
            if (SpecActive && !m_spec[wi]) begin
                m_shadow[wi] = m_data[wi]; m_sdirty[wi] = m_dirty[wi]; m_spec[wi] = 1;
            end
            m_data[wi] = DataIn; m_dirty[wi] = 1;
            if (!same) begin
                if (m_pend[wi] > 0)       m_pend[wi]--;
                else if (m_spend[wi] > 0) m_spend[wi]--;
            end
        end
    endtask

    // Model advances on the same edges as the design
    always @(posedge clk or posedge async_rst) begin
        if (async_rst)   model_reset();
        else if (clk_en) model_step();
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        for (int p = 0; p < RP; p++) begin
            cmp_ra = int'(ReadAddr[p*AW +: AW]);
            cmp("DataOut", p, 32'(DataOut[p*DW +: DW]), 32'(m_data[cmp_ra]));
            cmp("IsDirty", p, 32'(IsDirty[p]), 32'(m_dirty[cmp_ra]));
            cmp("HasPendingWrite", p, 32'(HasPendingWrite[p]),
                32'(m_pend[cmp_ra] != 0 || m_spend[cmp_ra] != 0));
            cmp("ParityErr", p, 32'(ParityErr[p]), 32'd0);
        end
        cmp("LineAllClean", -1, 32'(LineAllClean), 32'(model_clean()));
        cmp("FlushBusy", -1, 32'(FlushBusy), 32'(m_phase != 0));
        cmp("FlushDone", -1, 32'(FlushDone), 32'(m_done));
        cmp("WbValid", -1, 32'(WbValid), 32'(m_wb_valid));
        cmp("WbIndex", -1, 32'(WbIndex), 32'(m_wb_index));
        cmp("WbData", -1, 32'(WbData), 32'(m_wb_data));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        async_rst = 1'b1;
        #2;
        async_rst = 1'b0;
        #1;
    endtask

    task automatic write(input int a, input logic [DW-1:0] d, input bit spec);
        WriteEn = 1'b1; WriteAddr = 3'(a); DataIn = d; SpecActive = spec;
        tick();
        WriteEn = 1'b0; SpecActive = 1'b0;
    endtask

    task automatic reserve(input int a);
        ReserveEn = 1'b1; ReserveAddr = 3'(a);
        tick();
        ReserveEn = 1'b0;
    endtask

    task automatic pulse(input bit commit, input bit squash);
        SpecCommit = commit; SpecSquash = squash;
        tick();
        SpecCommit = 1'b0; SpecSquash = 1'b0;
    endtask

    task automatic look(input int a0, input int a1);
        ReadAddr = {3'(a1), 3'(a0)};
        #1;
    endtask

    // sel: 0 WbValid high, 1 FlushDone high, 2 FlushBusy low
    task automatic wait_for(input string name, input int sel);
        bit ok = 0;
        for (int k = 0; k < 20; k++) begin
            ok = (sel == 0) ? (WbValid === 1'b1) : (sel == 1) ? (FlushDone === 1'b1) : (FlushBusy === 1'b0);
            if (ok) break;
            tick();
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL timeout %s: condition not reached within 20 cycles at %0t", name, $time);
        end
    endtask

    initial begin
        async_rst = 1'b1;
        tick(); tick();
        async_rst = 1'b0;
        look(0, 0);
        cmp("reset_LineAllClean", -1, 32'(LineAllClean), 32'd1);
        cmp("reset_WbValid", -1, 32'(WbValid), 32'd0);

        write(3, 16'hBEEF, 0);
        look(3, 3);
        cmp("beef_both_ports", -1, 32'(DataOut), 32'hBEEFBEEF);
        cmp("beef_dirty", -1, 32'(IsDirty), 32'd3);
        cmp("beef_not_clean", -1, 32'(LineAllClean), 32'd0);

        reserve(2); reserve(2);
        write(2, 16'h0001, 0);
        look(2, 3);
        cmp("pend_after_one_write", 0, 32'(HasPendingWrite[0]), 32'd1);
        write(2, 16'h0002, 0);
        look(2, 3);
        cmp("pend_after_two_writes", 0, 32'(HasPendingWrite[0]), 32'd0);

        for (int k = 0; k < 16; k++) reserve(6);
        cmp("model_pend_saturates", -1, 32'(m_pend[6]), 32'd15);
        for (int k = 0; k < 14; k++) write(6, 16'(k), 0);
        look(6, 6);
        cmp("sat_pend_14_writes", 0, 32'(HasPendingWrite[0]), 32'd1);
        write(6, 16'h0066, 0);
        look(6, 6);
        cmp("sat_pend_15_writes", 0, 32'(HasPendingWrite[0]), 32'd0);

        write(5, 16'h1111, 0);
        write(5, 16'h2222, 1);
        look(5, 5);
        cmp("spec_write_visible", 0, 32'(DataOut[15:0]), 32'h2222);
        pulse(0, 1);
        look(5, 5);
        cmp("squash_restores", 0, 32'(DataOut[15:0]), 32'h1111);
        cmp("squash_dirty", 0, 32'(IsDirty[0]), 32'd1);
        write(5, 16'h2222, 1);
        pulse(1, 0);
        pulse(0, 1);
        look(5, 5);
        cmp("commit_keeps", 0, 32'(DataOut[15:0]), 32'h2222);

        do_reset();
        write(1, 16'h0101, 0);
        reserve(4); reserve(4);
        write(4, 16'h0404, 0);
        WbReady = 1'b0;
        FlushReq = 1'b1; tick(); FlushReq = 1'b0;
        wait_for("first_beat", 0);
        cmp("beat_index", -1, 32'(WbIndex), 32'd1);
        cmp("beat_data", -1, 32'(WbData), 32'h0101);
        for (int k = 0; k < 3; k++) begin
            tick();
            cmp("held_valid", -1, 32'(WbValid), 32'd1);
            cmp("held_index", -1, 32'(WbIndex), 32'd1);
        end
        WbReady = 1'b1; tick(); WbReady = 1'b0;
        look(1, 4);
        cmp("entry1_cleaned", 0, 32'(IsDirty[0]), 32'd0);
        wait_for("flush_done", 1);
        cmp("entry4_still_dirty", 1, 32'(IsDirty[1]), 32'd1);

        do_reset();
        write(0, 16'h5555, 0);
        FlushReq = 1'b1; tick(); FlushReq = 1'b0;
        wait_for("beat_entry0", 0);
        cmp("beat0_index", -1, 32'(WbIndex), 32'd0);
        WbReady = 1'b1; WriteEn = 1'b1; WriteAddr = 3'd0; DataIn = 16'hAAAA;
        #1;
        cmp("beat0_old_data", -1, 32'(WbData), 32'h5555);
        tick();
        WriteEn = 1'b0; WbReady = 1'b0;
        look(0, 0);
        cmp("entry0_new_data", 0, 32'(DataOut[15:0]), 32'hAAAA);
        cmp("entry0_still_dirty", 0, 32'(IsDirty[0]), 32'd1);
        WbReady = 1'b1;
        wait_for("drain_idle", 2);
        WbReady = 1'b0;
        look(0, 0);
        cmp("entry0_drained", 0, 32'(IsDirty[0]), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            clk_en      = ($urandom_range(0, 9) != 0);
            WriteEn     = 1'($urandom_range(0, 1));
            WriteAddr   = 3'($urandom);
            DataIn      = 16'($urandom);
            ReserveEn   = ($urandom_range(0, 3) == 0);
            ReserveAddr = 3'($urandom);
            SpecActive  = ($urandom_range(0, 9) < 3);
            SpecCommit  = ($urandom_range(0, 11) == 0);
            SpecSquash  = ($urandom_range(0, 15) == 0);
            FlushReq    = ($urandom_range(0, 6) == 0);
            WbReady     = 1'($urandom_range(0, 1));
            ReadAddr    = 6'($urandom);
            async_rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        async_rst = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
